// File: rtl/capture_ctrl_pkg.sv
// Shared types and constants for the trace capture sequencer.
// Provides the FSM state enum, trigger mode codes and trace geometry.
package capture_ctrl_pkg;

  localparam int TRACE_DEPTH = 256;
  localparam int TRACE_AW    = 8;

  localparam logic [1:0] CAP_AUTO   = 2'b00;
  localparam logic [1:0] CAP_NORMAL = 2'b01;
  localparam logic [1:0] CAP_SINGLE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRETRIG,
    ST_WAIT_TRIG,
    ST_POST,
    ST_DONE
  } cap_state_t;

  function automatic logic is_auto(
    input logic [1:0] m
  );
    return m == CAP_AUTO;
  endfunction

endpackage

// File: rtl/capture_ctrl_trig.sv
// Level/edge trigger detector: holds the previous accepted sample.
// Ports: clk, rst_n, clr (forget history), upd (accepted sample),
// sample, trig_level, trig_rising in; hit (combinational) out.
module trig_detect #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          upd,
  input  logic [DW-1:0] sample,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_rising,
  output logic          hit
);

  logic [DW-1:0] prev;
  logic          prev_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clr) begin
      prev_valid <= 1'b0;
    end else if (upd) begin
      prev       <= sample;
      prev_valid <= 1'b1;
    end
  end

  logic rise_hit;
  logic fall_hit;

  assign rise_hit = (prev < trig_level) &&
                    (sample >= trig_level);
  assign fall_hit = (prev > trig_level) &&
                    (sample <= trig_level);

  assign hit = prev_valid &&
               (trig_rising ? rise_hit : fall_hit);

endmodule

// File: rtl/capture_ctrl.sv
// Triggered trace acquisition into a double-banked sample RAM.
// In: clk, rst_n, sample/sample_vld, trig_level, trig_rising, mode,
// arm, vblnk. Out: wr_en/wr_addr/wr_data/wr_bank RAM write side,
// disp_bank/disp_start read side, busy, trig_seen, frame_done.
module capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int DEPTH   = TRACE_DEPTH,
  parameter int AW      = TRACE_AW,
  parameter int DW      = 8,
  parameter int PRETRIG = 32,
  parameter int TIMEOUT = 100000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] sample,
  input  logic          sample_vld,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_rising,
  input  logic [1:0]    mode,
  input  logic          arm,
  input  logic          vblnk,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          wr_bank,
  output logic          disp_bank,
  output logic [AW-1:0] disp_start,
  output logic          busy,
  output logic          trig_seen,
  output logic          frame_done
);

  localparam int TW = (TIMEOUT > 1) ?
                      $clog2(TIMEOUT) : 1;

  localparam logic [AW-1:0] PRE_LAST =
    AW'(PRETRIG - 1);
  localparam logic [AW-1:0] POST_LAST =
    AW'(DEPTH - PRETRIG - 1);
  localparam logic [AW-1:0] PRE_OFS =
    AW'(PRETRIG);
  localparam logic [TW-1:0] TO_LAST =
    TW'(TIMEOUT - 1);

  cap_state_t    state;
  logic [AW-1:0] wptr;
  logic [AW-1:0] pre_cnt;
  logic [AW-1:0] post_cnt;
  logic [TW-1:0] to_cnt;
  logic [AW-1:0] start_nxt;
  logic          run_auto;
  logic          vblnk_d;

  logic capturing;
  logic acc;
  logic hit;
  logic forced;
  logic trig;
  logic swap;
  logic start_run;

  assign capturing = (state == ST_PRETRIG)   ||
                     (state == ST_WAIT_TRIG) ||
                     (state == ST_POST);

  assign acc = sample_vld && capturing;

  // The timeout needs a trace started in auto mode, and a live
  // switch away from auto cancels it at once.
  assign forced = run_auto && is_auto(mode) &&
                  (to_cnt == TO_LAST);

  assign trig = acc && (state == ST_WAIT_TRIG) &&
                (hit || forced);

  assign swap = (state == ST_DONE) &&
                vblnk && !vblnk_d;

  assign start_run =
    ((state == ST_IDLE) &&
     ((mode != CAP_SINGLE) || arm)) ||
    (swap && (mode != CAP_SINGLE));

  assign busy = (state != ST_IDLE);

  trig_detect #(
    .DW(DW)
  ) u_trig (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (start_run),
    .upd         (acc),
    .sample      (sample),
    .trig_level  (trig_level),
    .trig_rising (trig_rising),
    .hit         (hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wptr       <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      to_cnt     <= '0;
      start_nxt  <= '0;
      run_auto   <= 1'b0;
      vblnk_d    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_bank    <= 1'b0;
      disp_bank  <= 1'b1;
      disp_start <= '0;
      trig_seen  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vblnk_d    <= vblnk;
      wr_en      <= acc;
      trig_seen  <= trig;
      frame_done <= swap;

      if (acc) begin
        wr_addr <= wptr;
        wr_data <= sample;
        wptr    <= wptr + 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
        end
        ST_PRETRIG: begin
          if (acc) begin
            pre_cnt <= pre_cnt + 1'b1;
            if (pre_cnt == PRE_LAST)
              state <= ST_WAIT_TRIG;
          end
        end
        ST_WAIT_TRIG: begin
          if (trig) begin
            // The trigger sample is the first post sample.
            start_nxt <= wptr - PRE_OFS;
            post_cnt  <= AW'(1);
            state     <= (POST_LAST == '0) ?
                         ST_DONE : ST_POST;
          end else if (acc && to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_POST: begin
          if (acc) begin
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt == POST_LAST)
              state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (swap) begin
            wr_bank    <= ~wr_bank;
            disp_bank  <= wr_bank;
            disp_start <= start_nxt;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Both IDLE exit and a non-single swap restart capture.
      if (start_run) begin
        state    <= ST_PRETRIG;
        pre_cnt  <= '0;
        post_cnt <= '0;
        to_cnt   <= '0;
        run_auto <= is_auto(mode);
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl.
// Scenario tasks compare the DUT against a trace-level model.
module tb_capture_ctrl;
  import capture_ctrl_pkg::*;

  localparam int DEPTH   = 256;
  localparam int PRETRIG = 32;
  localparam int TIMEOUT = 16;
  localparam int POSTN   = DEPTH - PRETRIG;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample = '0;
  logic       sample_vld = 1'b0;
  logic [7:0] trig_level = '0;
  logic       trig_rising = 1'b1;
  logic [1:0] mode = CAP_SINGLE;
  logic       arm = 1'b0;
  logic       vblnk = 1'b0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_bank;
  logic       disp_bank;
  logic [7:0] disp_start;
  logic       busy;
  logic       trig_seen;
  logic       frame_done;

  capture_ctrl #(
    .DEPTH(DEPTH), .AW(8), .DW(8),
    .PRETRIG(PRETRIG), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sample(sample), .sample_vld(sample_vld),
    .trig_level(trig_level),
    .trig_rising(trig_rising),
    .mode(mode), .arm(arm), .vblnk(vblnk),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_bank(wr_bank),
    .disp_bank(disp_bank),
    .disp_start(disp_start), .busy(busy),
    .trig_seen(trig_seen),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] wl_addr[$];
  logic [7:0] wl_data[$];
  int         tl[$];
  int         fd_cnt = 0;

  always @(negedge clk) begin
    if (trig_seen) tl.push_back(wl_addr.size());
    if (wr_en) begin
      wl_addr.push_back(wr_addr);
      wl_data.push_back(wr_data);
    end
    if (frame_done) fd_cnt++;
  end

  // Trace-level reference state.
  int         mw = 0;
  logic       exp_bank = 1'b0;
  logic [7:0] exp_start = '0;
  logic [7:0] stim[$];
  logic [7:0] lvl;
  bit         rise;
  bit         auto_m;
  int         last_ti;
  int         last_base;

  function automatic int model_trig();
    for (int i = PRETRIG; i < stim.size(); i++) begin
      if (rise ? (stim[i-1] < lvl && stim[i] >= lvl)
               : (stim[i-1] > lvl && stim[i] <= lvl))
        return i;
      if (auto_m && (i - PRETRIG) == TIMEOUT - 1)
        return i;
    end
    return -1;
  endfunction

  task automatic offer(input logic [7:0] v);
    if ($urandom_range(0, 3) == 0) begin
      sample = 8'($urandom);
      sample_vld = 1'b0;
      @(negedge clk);
    end
    sample = v;
    sample_vld = 1'b1;
    @(negedge clk);
    sample_vld = 1'b0;
  endtask

  task automatic wait_busy(input logic want,
                           output bit ok);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy === want) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_trace(input string nm);
    int ti, n, base, t0, errs;
    bit ok;
    trig_level = lvl;
    trig_rising = rise;
    ti = model_trig();
    if (ti < 0) begin
      $display("FAIL %s model: trigger %0d need >=0",
               nm, ti);
      $fatal(1);
    end
    n = ti + POSTN;
    base = wl_addr.size();
    t0 = tl.size();
    last_base = base;
    last_ti = -1;
    wait_busy(1'b1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s busy_rise: busy=%b need 1",
               nm, busy);
      return;
    end
    for (int k = 0; k < n; k++) offer(stim[k]);
    repeat (5) offer(8'($urandom));
    repeat (3) @(negedge clk);
    total++;
    if (wl_addr.size() - base != n) begin
      bad++;
      $display("FAIL %s nwrites: got %0d need %0d",
               nm, wl_addr.size() - base, n);
    end
    errs = 0;
    for (int k = 0; k < n; k++) begin
      if (base + k >= wl_addr.size()) break;
      if (wl_addr[base+k] !== 8'(mw + k) ||
          wl_data[base+k] !== stim[k])
        errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s wdata: got %0d bad writes need 0",
               nm, errs);
    end
    if (tl.size() > t0) last_ti = tl[t0] - base;
    total++;
    if (tl.size() - t0 != 1 || last_ti != ti) begin
      bad++;
      $display("FAIL %s trig: got n=%0d at %0d need 1 at %0d",
               nm, tl.size() - t0, last_ti, ti);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s done_busy: got %b need 1",
               nm, busy);
    end
    exp_start = 8'(mw + ti - PRETRIG);
    mw = (mw + n) % DEPTH;
  endtask

  task automatic do_swap(input string nm);
    int f0;
    mode = CAP_SINGLE;
    vblnk = 1'b0;
    repeat (2) @(negedge clk);
    f0 = fd_cnt;
    vblnk = 1'b1;
    repeat (3) @(negedge clk);
    vblnk = 1'b0;
    @(negedge clk);
    exp_bank = ~exp_bank;
    total++;
    if (fd_cnt != f0 + 1) begin
      bad++;
      $display("FAIL %s frame_done: got %0d need %0d",
               nm, fd_cnt - f0, 1);
    end
    total++;
    if (wr_bank !== exp_bank ||
        disp_bank !== ~exp_bank) begin
      bad++;
      $display("FAIL %s banks: got %b%b need %b%b",
               nm, wr_bank, disp_bank,
               exp_bank, ~exp_bank);
    end
    total++;
    if (disp_start !== exp_start) begin
      bad++;
      $display("FAIL %s disp_start: got %0d need %0d",
               nm, disp_start, exp_start);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_after: busy=%b need 0",
               nm, busy);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    total++;
    if ({wr_en, trig_seen, frame_done} !== 3'b000) begin
      bad++;
      $display("FAIL %s pulses: got %b need 000", nm,
               {wr_en, trig_seen, frame_done});
    end
    total++;
    if ({wr_addr, wr_data} !== 16'h0) begin
      bad++;
      $display("FAIL %s wr_bus: got %h need 0000", nm,
               {wr_addr, wr_data});
    end
    total++;
    if ({wr_bank, disp_bank} !== 2'b01) begin
      bad++;
      $display("FAIL %s banks: got %b need 01", nm,
               {wr_bank, disp_bank});
    end
    total++;
    if (disp_start !== 8'h0) begin
      bad++;
      $display("FAIL %s disp_start: got %0d need 0",
               nm, disp_start);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode = CAP_SINGLE;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset busy: got %b need 0", busy);
    end
  endtask

  task automatic test_single_no_arm();
    int nb, w0;
    nb = 0;
    w0 = wl_addr.size();
    for (int k = 0; k < 12; k++) begin
      sample = 8'($urandom);
      sample_vld = 1'b1;
      @(negedge clk);
      if (busy !== 1'b0) nb++;
    end
    sample_vld = 1'b0;
    total++;
    if (nb != 0 || wl_addr.size() != w0) begin
      bad++;
      $display("FAIL no_arm: busy %0d writes %0d need 0 0",
               nb, wl_addr.size() - w0);
    end
  endtask

  task automatic test_ramp();
    stim.delete();
    for (int k = 0; k < 400; k++) stim.push_back(8'(k));
    lvl = 8'd128;
    rise = 1;
    auto_m = 0;
    mode = CAP_NORMAL;
    do_trace("ramp");
    total++;
    if (last_ti < 0 ||
        wl_data[last_base+last_ti] !== 8'd128) begin
      bad++;
      $display("FAIL ramp trig_value: idx %0d need 128",
               last_ti);
    end
    do_swap("ramp");
    total++;
    if (wr_bank !== 1'b1 || disp_bank !== 1'b0) begin
      bad++;
      $display("FAIL ramp bank_abs: got %b%b need 10",
               wr_bank, disp_bank);
    end
  endtask

  task automatic test_falling();
    stim.delete();
    for (int k = 0; k < PRETRIG; k++)
      stim.push_back(8'($urandom_range(0, 100)));
    stim.push_back(8'd80);
    stim.push_back(8'd100);
    stim.push_back(8'd100);
    stim.push_back(8'd100);
    stim.push_back(8'd130);
    stim.push_back(8'd150);
    stim.push_back(8'd101);
    stim.push_back(8'd100);
    for (int k = 0; k < 260; k++)
      stim.push_back(8'($urandom));
    lvl = 8'd100;
    rise = 0;
    auto_m = 0;
    mode = CAP_NORMAL;
    do_trace("falling");
    total++;
    if (last_ti != 39) begin
      bad++;
      $display("FAIL falling trig_idx: got %0d need 39",
               last_ti);
    end
    do_swap("falling");
  endtask

  task automatic test_auto_timeout();
    stim.delete();
    for (int k = 0; k < 400; k++) stim.push_back(8'd50);
    lvl = 8'd200;
    rise = 1;
    auto_m = 1;
    mode = CAP_AUTO;
    do_trace("auto");
    total++;
    if (last_ti != PRETRIG + TIMEOUT - 1) begin
      bad++;
      $display("FAIL auto forced_idx: got %0d need %0d",
               last_ti, PRETRIG + TIMEOUT - 1);
    end
    do_swap("auto");
  endtask

  task automatic test_single_arm();
    int f0;
    stim.delete();
    for (int k = 0; k < 1200; k++)
      stim.push_back(8'($urandom));
    lvl = 8'd128;
    rise = 1;
    auto_m = 0;
    mode = CAP_SINGLE;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    do_trace("single");
    do_swap("single");
    f0 = fd_cnt;
    vblnk = 1'b1;
    repeat (3) @(negedge clk);
    vblnk = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (fd_cnt != f0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single 2nd_vblnk: fd %0d busy %b need 0 0",
               fd_cnt - f0, busy);
    end
  endtask

  task automatic test_vblnk_hold_wrap();
    int i, f0;
    i = PRETRIG + ((10 - mw - PRETRIG) % DEPTH + DEPTH) % DEPTH;
    stim.delete();
    for (int k = 0; k < i; k++) stim.push_back(8'd0);
    stim.push_back(8'd200);
    for (int k = 0; k < POSTN + 8; k++)
      stim.push_back(8'($urandom));
    lvl = 8'd128;
    rise = 1;
    auto_m = 0;
    f0 = fd_cnt;
    vblnk = 1'b1;
    mode = CAP_NORMAL;
    do_trace("hold");
    repeat (6) @(negedge clk);
    total++;
    if (fd_cnt != f0) begin
      bad++;
      $display("FAIL hold early_swap: got %0d need 0",
               fd_cnt - f0);
    end
    do_swap("hold");
    total++;
    if (disp_start !== 8'd234) begin
      bad++;
      $display("FAIL hold wrap: got %0d need 234",
               disp_start);
    end
  endtask

  task automatic test_reset_post();
    int f0, t0;
    bit ok;
    stim.delete();
    for (int k = 0; k < 40; k++) stim.push_back(8'd0);
    stim.push_back(8'd200);
    for (int k = 0; k < 60; k++)
      stim.push_back(8'($urandom));
    trig_level = 8'd128;
    trig_rising = 1'b1;
    t0 = tl.size();
    mode = CAP_NORMAL;
    wait_busy(1'b1, ok);
    for (int k = 0; k < stim.size(); k++) offer(stim[k]);
    total++;
    if (!ok || tl.size() != t0 + 1) begin
      bad++;
      $display("FAIL rst_post trig: got %0d need 1",
               tl.size() - t0);
    end
    f0 = fd_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_post");
    mode = CAP_SINGLE;
    vblnk = 1'b1;
    repeat (2) @(negedge clk);
    vblnk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vblnk = 1'b1;
    repeat (3) @(negedge clk);
    vblnk = 1'b0;
    @(negedge clk);
    total++;
    if (fd_cnt != f0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_post no_swap: fd %0d busy %b need 0 0",
               fd_cnt - f0, busy);
    end
    mw = 0;
    exp_bank = 1'b0;
    exp_start = '0;
  endtask

  task automatic test_back_to_back();
    stim.delete();
    for (int k = 0; k < 1400; k++)
      stim.push_back(8'($urandom));
    lvl = 8'($urandom_range(20, 230));
    rise = 1'($urandom_range(0, 1));
    auto_m = 0;
    mode = CAP_NORMAL;
    do_trace("after_rst");
    do_swap("after_rst");
  endtask

  initial begin
    test_reset();
    test_single_no_arm();
    test_ramp();
    test_falling();
    test_auto_timeout();
    test_single_arm();
    test_vblnk_hold_wrap();
    test_reset_post();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time %0t need finish", $time);
    $fatal(1);
  end

endmodule
